// File: rtl/mul_pkg.sv
// Shared definitions for the shared shift-add multiplier: FSM states, default
// operand width, requester count and the round-robin winner selection.
package mul_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned NUM_REQ   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A lone requester always wins; on contention the pointer decides.
    function automatic logic pick_winner(input logic [NUM_REQ-1:0] req, input logic ptr);
        case (req)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ptr;
        endcase
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/grant and response bundle between two clients and the shared multiplier.
interface mul_share_arbiter_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   mcand0;
    logic [WIDTH-1:0]   mplier0;
    logic [WIDTH-1:0]   mcand1;
    logic [WIDTH-1:0]   mplier1;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_data;

    modport master (
        output req, mcand0, mplier0, mcand1, mplier1, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, mcand0, mplier0, mcand1, mplier1, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/shift_add_core.sv
// Sequential unsigned shift-add multiplier datapath: one partial-product step
// per cycle, product read directly from the {A,Q} accumulator pair.
module shift_add_core
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               last_step,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum   = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        if (load) begin
            a_d   = '0;
            q_d   = mplier;
            m_d   = mcand;
            cnt_d = '0;
        end else if (step) begin
            // A holds WIDTH+1 bits so the adder carry shifts down instead of being lost.
            a_d   = {1'b0, sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_step = step && (cnt_q == CW'(WIDTH - 1));
    assign product   = {a_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier between
// two requesters; returns each product tagged with its requester id.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    mul_share_arbiter_if.slave  bus
);
    state_e               state_q;
    logic                 ptr_q;
    logic                 id_q;
    logic                 win;
    logic                 load;
    logic                 last_step;
    logic [WIDTH-1:0]     sel_mcand;
    logic [WIDTH-1:0]     sel_mplier;
    logic [NUM_REQ-1:0]   gnt;
    logic [2*WIDTH-1:0]   product;

    // Grant is issued combinationally in the IDLE cycle so the capture edge
    // and the grant pulse coincide; reset masks it.
    always_comb begin
        win        = pick_winner(bus.req, ptr_q);
        load       = (state_q == ST_IDLE) && (|bus.req) && !rst;
        sel_mcand  = win ? bus.mcand1  : bus.mcand0;
        sel_mplier = win ? bus.mplier1 : bus.mplier0;
        gnt        = '0;
        if (load) begin
            gnt[win] = 1'b1;
        end
    end

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (state_q == ST_RUN),
        .mcand     (sel_mcand),
        .mplier    (sel_mplier),
        .last_step (last_step),
        .product   (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        id_q    <= win;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_step) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Pointer moves only on completion, favouring the other requester next.
                    if (bus.rsp_ready) begin
                        ptr_q   <= ~id_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = product;

endmodule
